// File: rtl/sensor_seq_pkg.sv
// sensor_seq_pkg
// Shared definitions for the sensor trigger sequencer:
//   - sequencer state encoding (IDLE, RUN, CMPL)
//   - sensor slot indices, in the same order as the driver's enumeration
//     and the timing manager's enable bits
//   - default widths and the cycle-counter width helper
// Optional feature macro: SENSOR_SEQ_TIMEOUT_EN (used by the slot logic).
package sensor_seq_pkg;

  localparam int DEF_NUM_SENSORS = 10;
  localparam int DEF_DELAY_W     = 16;
  localparam int DEF_TIMEOUT_W   = 16;

  localparam int SENS_ADC     = 0;
  localparam int SENS_ENCODER = 1;
  localparam int SENS_AMDS_0  = 2;
  localparam int SENS_AMDS_1  = 3;
  localparam int SENS_AMDS_2  = 4;
  localparam int SENS_AMDS_3  = 5;
  localparam int SENS_EDDY_0  = 6;
  localparam int SENS_EDDY_1  = 7;
  localparam int SENS_EDDY_2  = 8;
  localparam int SENS_EDDY_3  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMPL = 2'd2
  } seq_state_t;

  // One extra bit so that start_delay + timeout never wraps.
  function automatic int cnt_width(input int delay_w, input int timeout_w);
    return ((delay_w > timeout_w) ? delay_w : timeout_w) + 1;
  endfunction

endpackage

// File: rtl/sensor_seq_slot.sv
// sensor_seq_slot
// Per-sensor state of one sequencer slot: start compare, started flag,
// done rising-edge detection, optional deadline compare, and the latched
// done / sticky timeout registers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   seq_start       new sequence accepted (clears done/started)
//   run             sequencer is in RUN
//   en              latched enable for this slot
//   clear_flags     clears the sticky timeout flag
//   cnt             sequence cycle counter (0 in the first RUN cycle)
//   delay, timeout  start offset and timeout (0 = no timeout)
//   done_in         level done from the sensor
//   start           one-cycle start pulse
//   done            latched qualified done
//   timeout_flag    sticky timeout flag
// Macro SENSOR_SEQ_TIMEOUT_EN enables the deadline logic; without it the
// timeout input is ignored and timeout_flag is 0.
module sensor_seq_slot
  import sensor_seq_pkg::*;
#(
  parameter int DELAY_W   = DEF_DELAY_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int CNT_W     = cnt_width(DEF_DELAY_W, DEF_TIMEOUT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seq_start,
  input  logic                 run,
  input  logic                 en,
  input  logic                 clear_flags,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [DELAY_W-1:0]   delay,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 done_in,
  output logic                 start,
  output logic                 done,
  output logic                 timeout_flag
);

  logic             started_reg;
  logic             done_d_reg;
  logic             done_reg;
  logic [CNT_W-1:0] delay_ext;
  logic             hit_start;
  logic             done_evt;
  logic             timeout_evt;

  assign delay_ext = CNT_W'(delay);
  assign hit_start = run & en & (cnt == delay_ext);
  // started_reg only becomes visible the cycle after the start pulse, so
  // an edge in the start cycle itself is ignored.
  assign done_evt  = run & en & started_reg & done_in & ~done_d_reg;

`ifdef SENSOR_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] deadline;
  logic             flag_reg;

  assign deadline    = delay_ext + CNT_W'(timeout);
  assign timeout_evt = run & en & (timeout != '0) & ~done_reg & (cnt == deadline);

  // Set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flag_reg <= 1'b0;
    else if (timeout_evt)
      flag_reg <= 1'b1;
    else if (clear_flags)
      flag_reg <= 1'b0;
  end

  assign timeout_flag = flag_reg;
`else
  logic unused_timeout;

  assign unused_timeout = ^{timeout, clear_flags};
  assign timeout_evt    = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_reg <= 1'b0;
      done_d_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_d_reg <= done_in;
      if (seq_start) begin
        started_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else begin
        if (hit_start)
          started_reg <= 1'b1;
        if (done_evt || timeout_evt)
          done_reg <= 1'b1;
      end
    end
  end

  assign start = hit_start;
  assign done  = done_reg;

endmodule

// File: rtl/sensor_trigger_sequencer.sv
// sensor_trigger_sequencer
// Issues per-sensor start pulses at programmable offsets after each
// accepted scheduler trigger, tracks each sensor's done edge (with optional
// timeout) and reports completion back to the timing manager.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   trigger        single-cycle trigger
//   en_bits        sensor enables, latched on an accepted trigger
//   start_delay    packed per-slot start offsets
//   timeout        max cycles from start to done (0 = disabled)
//   done_in        level done signals from the sensors
//   clear_flags    clears timeout_flags and overrun
//   start_out      one-cycle start pulses
//   done_out       latched qualified done vector
//   timeout_flags  sticky per-slot timeout flags
//   overrun        sticky: trigger arrived while busy
//   busy           high in RUN and CMPL
//   seq_done       one-cycle completion pulse
// Macro SENSOR_SEQ_TIMEOUT_EN enables the timeout feature.
module sensor_trigger_sequencer
  import sensor_seq_pkg::*;
#(
  parameter int NUM_SENSORS = DEF_NUM_SENSORS,
  parameter int DELAY_W     = DEF_DELAY_W,
  parameter int TIMEOUT_W   = DEF_TIMEOUT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trigger,
  input  logic [NUM_SENSORS-1:0]         en_bits,
  input  logic [NUM_SENSORS*DELAY_W-1:0] start_delay,
  input  logic [TIMEOUT_W-1:0]           timeout,
  input  logic [NUM_SENSORS-1:0]         done_in,
  input  logic                           clear_flags,
  output logic [NUM_SENSORS-1:0]         start_out,
  output logic [NUM_SENSORS-1:0]         done_out,
  output logic [NUM_SENSORS-1:0]         timeout_flags,
  output logic                           overrun,
  output logic                           busy,
  output logic                           seq_done
);

  localparam int CNT_W = cnt_width(DELAY_W, TIMEOUT_W);

  seq_state_t             state_reg;
  seq_state_t             state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [NUM_SENSORS-1:0] en_q_reg;
  logic                   overrun_reg;
  logic                   accept;
  logic                   run;
  logic                   all_done;

  // Disabled slots never set done_out, so treat them as already done.
  assign all_done = &(done_out | ~en_q_reg);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trigger && (en_bits != '0)) state_next = RUN;
      RUN:     if (all_done) state_next = CMPL;
      CMPL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    accept   = 1'b0;
    run      = 1'b0;
    busy     = 1'b0;
    seq_done = 1'b0;
    case (state_reg)
      IDLE: accept = trigger & (en_bits != '0);
      RUN: begin
        run  = 1'b1;
        busy = 1'b1;
      end
      CMPL: begin
        busy     = 1'b1;
        seq_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequence counter, latched enables and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      en_q_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg  <= '0;
        en_q_reg <= en_bits;
      end else if (run && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (trigger && (state_reg != IDLE))
        overrun_reg <= 1'b1;
      else if (clear_flags)
        overrun_reg <= 1'b0;
    end
  end

  assign overrun = overrun_reg;

  generate
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_slot
      sensor_seq_slot #(
        .DELAY_W   (DELAY_W),
        .TIMEOUT_W (TIMEOUT_W),
        .CNT_W     (CNT_W)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .seq_start    (accept),
        .run          (run),
        .en           (en_q_reg[gi]),
        .clear_flags  (clear_flags),
        .cnt          (cnt_reg),
        .delay        (start_delay[gi*DELAY_W +: DELAY_W]),
        .timeout      (timeout),
        .done_in      (done_in[gi]),
        .start        (start_out[gi]),
        .done         (done_out[gi]),
        .timeout_flag (timeout_flags[gi])
      );
    end
  endgenerate

endmodule

// File: doc/sensor_trigger_sequencer.md
# sensor_trigger_sequencer

Sequences the per-sensor acquisition starts that follow each scheduler trigger from the timing manager. On an accepted trigger it issues a start pulse to each enabled sensor (ADC, encoder, AMDS 0–3, eddy 0–3) at a programmable cycle offset. It then tracks each sensor's done edge and forces completion on timeout, so the timing manager's all-done condition cannot hang. It sits between the timing manager's `trigger`/`en_*` outputs and the sensor interface IPs, and returns the qualified `done_out` vector to the timing manager's done inputs.

## Interface
- `NUM_SENSORS`, 10, number of sensor slots; bit order matches the enable-bit order: 0 ADC, 1 encoder, 2–5 AMDS 0–3, 6–9 eddy 0–3.
- `DELAY_W`, 16, width of each start offset.
- `TIMEOUT_W`, 16, width of the timeout value.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in 1: single-cycle trigger from the timing manager.
- `en_bits` in NUM_SENSORS: sensor enables; latched on an accepted trigger.
- `start_delay` in NUM_SENSORS*DELAY_W: offset for slot i at bits [i*DELAY_W +: DELAY_W]; quasi-static.
- `timeout` in TIMEOUT_W: maximum cycles from start to done; 0 disables the timeout; quasi-static.
- `done_in` in NUM_SENSORS: level done signals from the sensors.
- `clear_flags` in 1: clears the sticky flags.
- `start_out` out NUM_SENSORS: one-cycle start pulses.
- `done_out` out NUM_SENSORS: qualified, latched done, fed to the timing manager.
- `timeout_flags` out NUM_SENSORS: sticky per-sensor timeout flags.
- `overrun` out 1: sticky; a trigger arrived while busy.
- `busy` out 1: high in RUN and CMPL.
- `seq_done` out 1: one-cycle pulse when a sequence completes.

## Operation
- FSM states:
  - IDLE: a trigger with a nonzero `en_bits` → RUN. This latches `en_q <= en_bits`, clears `done_out`, and sets `cnt <= 0`. A trigger with `en_bits == 0` is ignored and no flags change.
  - RUN: `cnt` increments each cycle and saturates at all-ones. `cnt` width is max(DELAY_W, TIMEOUT_W)+1.
    - `start_out[i]` pulses in the cycle where `en_q[i] & cnt == start_delay[i]`, and `started[i]` is set.
    - A rising edge of `done_in[i]` seen while `started[i]` is set (the cycle after the start pulse or later) sets `done_out[i]` at the next edge. Edges seen at or before the start cycle are ignored.
    - Deadline: when `cnt == start_delay[i] + timeout` (full-width sum), `timeout != 0`, and `done_out[i]` is 0, then `done_out[i]` and `timeout_flags[i]` are set at the next edge.
    - When every `en_q` bit has `done_out` set → CMPL.
  - CMPL: `seq_done` is 1 for this cycle; the FSM → IDLE.
- A trigger in RUN or CMPL is dropped and sets `overrun`.
- `done_out` holds its value after completion until the next accepted trigger.
- `clear_flags` clears `timeout_flags` and `overrun`. A set event in the same cycle wins over the clear.
- Slots whose `en_q` bit is 0 never pulse, never time out, and keep `done_out` at 0.
- `en_bits` changes during RUN have no effect.

## Timing
- Reset values: every output is 0. State is IDLE, and `cnt`, `en_q`, `started` and the done edge registers are 0.
- A trigger sampled at edge T gives `cnt == 0` during cycle T+1. A slot with `start_delay = d` has its start pulse in cycle T+1+d.
- A done edge sampled at edge E sets `done_out` from E+1.
- Completion: `seq_done` is asserted one cycle after the last `done_out` bit rises.
- Reset asserted mid-sequence aborts the sequence immediately. No start pulse is emitted after reset.
- If several slots share the same delay, they pulse in the same cycle.

## Configuration
- `SENSOR_SEQ_TIMEOUT_EN` defined: the deadline logic and `timeout_flags` are implemented.
- Macro undefined: the `timeout` input is ignored, `timeout_flags` is tied to 0, and RUN waits indefinitely for done edges. The ports remain present.

## Structure
- Package `sensor_seq_pkg` holds:
  - the state enum (IDLE, RUN, CMPL);
  - the sensor index constants (SENS_ADC=0 … SENS_EDDY_3=9), shared with the driver's enumeration order;
  - the default widths.
- Sub-module `sensor_seq_slot` holds the per-slot state: start compare, started flag, done edge detection, deadline compare, and done/timeout registers. It is instantiated NUM_SENSORS times; the top holds the FSM and `cnt`.

## Test plan
- `en_bits = 0x001`, delay0 = 0, `done_in[0]` rises 5 cycles after the start → start at T+1, `done_out[0]` at T+7, `seq_done` at T+8, no flags set.
- `en_bits = 0x003`, delays 10/3 → `start_out[1]` at T+4 and `start_out[0]` at T+11; completion only after both done edges.
- `en_bits = 0x004`, `timeout = 20`, `done_in` never rises → `done_out[2]` and `timeout_flags[2]` set at T+22, `seq_done` at T+23; `clear_flags` then clears the flag, and `done_out` stays 1.
- `done_in[0]` held high from before the trigger → no done until a fresh 0→1 edge after the start.
- A second trigger during RUN → ignored and `overrun = 1`. A trigger with `en_bits = 0` → stays in IDLE, no start pulses.
- `rst` pulsed during RUN between starts → all outputs 0 and no further starts; a new trigger then runs normally.
